// File: rtl/xenos_fault_logger_if.sv
// Record stream from the fault logger to the host/CPU bridge (valid/ready handshake).
interface xenos_fault_logger_if #(
  parameter int unsigned TS_W = 32
) ();
  logic             out_valid;
  logic             out_ready;
  logic [TS_W+10:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/xenos_fault_logger.sv
// Timestamped fault-event logger: edge/change detect, record FIFO, overflow stats.
// Optional XENOS_LOG_DEDUP_EN suppresses repeats of the last pushed code/channel within HOLDOFF cycles.
module xenos_fault_logger #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned HOLDOFF = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fault_detected,
  input  logic [3:0]               fault_code,
  input  logic [3:0]               fault_channel,
  input  logic [2:0]               current_state,
  input  logic                     clear,
  xenos_fault_logger_if.master     host,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned REC_W = TS_W + 11;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF == 0) begin : g_param_check
    $error("xenos_fault_logger: DEPTH must be a power of two >= 2 and HOLDOFF nonzero");
  end

  logic [TS_W-1:0]  ts_q;
  logic             fd_q;
  logic [3:0]       code_q;
  logic [3:0]       chan_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [REC_W-1:0] mem [DEPTH];

  logic             evt_c;
  logic             suppress_c;
  logic             pop_c;
  logic             full_c;
  logic             push_c;
  logic             drop_c;
  logic [AW-1:0]    rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic [REC_W-1:0] rec_c;
  logic [REC_W-1:0] head_n;

  // New fault condition: rising flag, or a change of code/channel while asserted
  assign evt_c = fault_detected &&
                 (!fd_q || (fault_code != code_q) || (fault_channel != chan_q));

`ifdef XENOS_LOG_DEDUP_EN
  logic            last_vld;
  logic [3:0]      last_code;
  logic [3:0]      last_chan;
  logic [TS_W-1:0] last_ts;
  logic [TS_W-1:0] elapsed_c;

  // Modular subtraction keeps the window correct across timestamp wrap
  assign elapsed_c  = ts_q - last_ts;
  assign suppress_c = last_vld && (fault_code == last_code) &&
                      (fault_channel == last_chan) && (elapsed_c < TS_W'(HOLDOFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld  <= 1'b0;
      last_code <= 4'd0;
      last_chan <= 4'd0;
      last_ts   <= '0;
    end else if (clear) begin
      last_vld  <= 1'b0;
      last_code <= 4'd0;
      last_chan <= 4'd0;
      last_ts   <= '0;
    end else if (push_c) begin
      last_vld  <= 1'b1;
      last_code <= fault_code;
      last_chan <= fault_channel;
      last_ts   <= ts_q;
    end
  end
`else
  assign suppress_c = 1'b0;
`endif

  assign rec_c  = {ts_q, current_state, fault_channel, fault_code};
  assign pop_c  = host.out_valid && host.out_ready;
  assign full_c = (level == LW'(DEPTH));
  assign push_c = evt_c && !suppress_c && (!full_c || pop_c);
  assign drop_c = evt_c && !suppress_c && full_c && !pop_c;

  always_comb begin
    rd_ptr_n = rd_ptr;
    level_n  = level + LW'(push_c) - LW'(pop_c);
    if (pop_c) begin
      rd_ptr_n = rd_ptr + AW'(1);
    end
    // Bypass when the record being written becomes the new head
    head_n = (push_c && (wr_ptr == rd_ptr_n)) ? rec_c : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_c && !clear) begin
      mem[wr_ptr] <= rec_c;
    end
  end

  // Timestamp, detect history, pointers and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q           <= '0;
      fd_q           <= 1'b0;
      code_q         <= 4'd0;
      chan_q         <= 4'd0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      overflow       <= 1'b0;
      drop_cnt       <= 16'd0;
      host.out_valid <= 1'b0;
      host.out_data  <= '0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      fd_q   <= fault_detected;
      code_q <= fault_code;
      chan_q <= fault_channel;
      if (clear) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        level          <= '0;
        overflow       <= 1'b0;
        drop_cnt       <= 16'd0;
        host.out_valid <= 1'b0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        rd_ptr         <= rd_ptr_n;
        level          <= level_n;
        host.out_valid <= (level_n != '0);
        host.out_data  <= head_n;
        if (drop_c) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xenos_fault_logger.sv
// Directed bench for xenos_fault_logger: vector table plus multi-cycle sequences.
module tb_xenos_fault_logger;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 32;
  localparam int unsigned LW    = 5;
  localparam int unsigned RW    = TS_W + 11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fault_detected = 1'b0;
  logic [3:0]      fault_code = 4'd0;
  logic [3:0]      fault_channel = 4'd0;
  logic [2:0]      current_state = 3'd0;
  logic            clear = 1'b0;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [15:0]     drop_cnt;

  int              vectors = 0;
  int              miscompares = 0;
  logic [TS_W-1:0] cyc = '0;
  logic [RW-1:0]   expq[$];
  logic [RW-1:0]   tmp;
  logic [TS_W-1:0] t0;

  typedef struct {
    int n; int fd; int code; int chan; int st; int rdy; int clr;
    int ev; int lv; int ovf; int drop;
    int chk; int ts; int dst; int dch; int dcd;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  xenos_fault_logger_if #(.TS_W(TS_W)) host ();

  xenos_fault_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .HOLDOFF(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .fault_detected(fault_detected),
    .fault_code    (fault_code),
    .fault_channel (fault_channel),
    .current_state (current_state),
    .clear         (clear),
    .host          (host),
    .level         (level),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  function automatic logic [RW-1:0] rec(input logic [TS_W-1:0] ts, input int st,
                                        input int ch, input int cd);
    return {ts, 3'(st), 4'(ch), 4'(cd)};
  endfunction

  function automatic vec_t mk(int n, int fd, int code, int chan, int st, int rdy, int clr,
                              int ev, int lv, int chk, int ts, int dst, int dch, int dcd);
    vec_t v;
    v = '{n, fd, code, chan, st, rdy, clr, ev, lv, 0, 0, chk, ts, dst, dch, dcd};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int fd, input int cd, input int ch, input int st);
    fault_detected = 1'(fd);
    fault_code     = 4'(cd);
    fault_channel  = 4'(ch);
    current_state  = 3'(st);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    host.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 64'(host.out_valid), 64'd0);
    chk("reset level", 64'(level), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset drop", 64'(drop_cnt), 64'd0);
    chk("reset data", 64'(host.out_data), 64'd0);
    rst = 1'b0;
    cyc = '0;

`ifdef XENOS_LOG_DEDUP_EN
    repeat (5) step();
    t0 = cyc;
    drive(1, 9, 1, 0); step();
    chk("dd first level", 64'(level), 64'd1);
    chk("dd first data", 64'(host.out_data), 64'(rec(t0, 0, 1, 9)));
    drive(0, 9, 1, 0); step();
    while (cyc < t0 + 100) step();
    drive(1, 9, 1, 0); step();
    chk("dd suppressed level", 64'(level), 64'd1);
    chk("dd suppressed drop", 64'(drop_cnt), 64'd0);
    drive(0, 9, 1, 0);
    while (cyc < t0 + 1100) step();
    drive(1, 9, 1, 0); step();
    chk("dd logged level", 64'(level), 64'd2);
    chk("dd logged drop", 64'(drop_cnt), 64'd0);
    chk("dd logged overflow", 64'(overflow), 64'd0);
    chk("dd head data", 64'(host.out_data), 64'(rec(t0, 0, 1, 9)));
`else
    // n, fd, code, chan, st, rdy, clr, exp valid, exp level, check data, ts, st, chan, code
    tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 3, 5, 2, 0, 0, 1, 1, 1, 10, 2, 5, 3));
    tbl.push_back(mk( 4, 1, 3, 5, 2, 0, 0, 1, 1, 1, 10, 2, 5, 3));
    tbl.push_back(mk( 1, 1, 7, 5, 2, 0, 0, 1, 2, 1, 10, 2, 5, 3));
    tbl.push_back(mk(14, 1, 7, 5, 2, 0, 0, 1, 2, 1, 10, 2, 5, 3));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 0, 0, 1, 2, 1, 10, 2, 5, 3));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 1, 0, 1, 1, 1, 15, 2, 5, 7));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 7, 5, 2, 0, 0, 1, 1, 1, 34, 2, 5, 7));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 0, 0, 1, 1, 1, 34, 2, 5, 7));
    tbl.push_back(mk( 1, 1, 7, 5, 2, 0, 0, 1, 2, 1, 34, 2, 5, 7));
    tbl.push_back(mk( 1, 0, 7, 5, 2, 0, 0, 1, 2, 1, 34, 2, 5, 7));
    tbl.push_back(mk( 1, 1, 1, 11, 4, 1, 0, 1, 2, 1, 36, 2, 5, 7));
    tbl.push_back(mk( 1, 1, 1, 11, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 3, 1, 1, 11, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 11, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 11, 4, 0, 0, 1, 1, 1, 44, 4, 11, 1));
    tbl.push_back(mk( 1, 1, 1, 12, 6, 0, 0, 1, 2, 1, 44, 4, 11, 1));
    tbl.push_back(mk( 1, 0, 1, 12, 6, 0, 0, 1, 2, 1, 44, 4, 11, 1));
    tbl.push_back(mk( 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[r]) begin
      drive(tbl[r].fd, tbl[r].code, tbl[r].chan, tbl[r].st);
      host.out_ready = 1'(tbl[r].rdy);
      clear          = 1'(tbl[r].clr);
      repeat (tbl[r].n) step();
      chk($sformatf("row%0d valid", r), 64'(host.out_valid), 64'(tbl[r].ev));
      chk($sformatf("row%0d level", r), 64'(level), 64'(tbl[r].lv));
      chk($sformatf("row%0d overflow", r), 64'(overflow), 64'(tbl[r].ovf));
      chk($sformatf("row%0d drop", r), 64'(drop_cnt), 64'(tbl[r].drop));
      if (tbl[r].chk != 0)
        chk($sformatf("row%0d data", r), 64'(host.out_data),
            64'(rec(TS_W'(tbl[r].ts), tbl[r].dst, tbl[r].dch, tbl[r].dcd)));
    end
    host.out_ready = 1'b0;
    clear = 1'b0;

    // Overflow: 20 distinct events into a 16-deep FIFO with no consumer
    for (int i = 0; i < 20; i++) begin
      drive(1, i % 16, i / 16, i % 8);
      if (expq.size() < DEPTH) expq.push_back(rec(cyc, i % 8, i / 16, i % 16));
      step();
    end
    drive(0, 0, 0, 0); step();
    chk("ovf level", 64'(level), 64'd16);
    chk("ovf flag", 64'(overflow), 64'd1);
    chk("ovf drop", 64'(drop_cnt), 64'd4);
    chk("ovf head", 64'(host.out_data), 64'(expq[0]));

    // Full FIFO with a pop and a new event in the same cycle
    drive(1, 10, 9, 5);
    host.out_ready = 1'b1;
    tmp = expq.pop_front();
    expq.push_back(rec(cyc, 5, 9, 10));
    step();
    host.out_ready = 1'b0;
    drive(0, 0, 0, 0);
    chk("fullpop level", 64'(level), 64'd16);
    chk("fullpop drop", 64'(drop_cnt), 64'd4);
    chk("fullpop head", 64'(host.out_data), 64'(expq[0]));

    host.out_ready = 1'b1;
    for (int k = 0; k < int'(DEPTH) + 4 && expq.size() != 0; k++) begin
      chk($sformatf("drain%0d valid", k), 64'(host.out_valid), 64'd1);
      chk($sformatf("drain%0d data", k), 64'(host.out_data), 64'(expq[0]));
      step();
      tmp = expq.pop_front();
    end
    chk("drained valid", 64'(host.out_valid), 64'd0);
    chk("drained level", 64'(level), 64'd0);
    host.out_ready = 1'b0;

    // Backpressure stability, then clear with a fault that persists
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      drive(1, i + 1, 2, 1);
      step();
    end
    chk("bp level", 64'(level), 64'd5);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("bp%0d stable", j), 64'(host.out_data), 64'(rec(t0, 1, 2, 1)));
      chk($sformatf("bp%0d valid", j), 64'(host.out_valid), 64'd1);
    end
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr level", 64'(level), 64'd0);
    chk("clr valid", 64'(host.out_valid), 64'd0);
    chk("clr overflow", 64'(overflow), 64'd0);
    chk("clr drop", 64'(drop_cnt), 64'd0);
    repeat (3) step();
    chk("persist level", 64'(level), 64'd0);
    chk("persist valid", 64'(host.out_valid), 64'd0);
    drive(0, 0, 0, 0); step();

    // Asynchronous reset in the middle of operation
    drive(1, 2, 3, 1); step();
    drive(1, 4, 3, 1); step();
    drive(0, 0, 0, 0); step();
    chk("pre-rst level", 64'(level), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", 64'(host.out_valid), 64'd0);
    chk("async rst level", 64'(level), 64'd0);
    chk("async rst data", 64'(host.out_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = '0;
    drive(1, 6, 7, 3); step();
    chk("post-rst level", 64'(level), 64'd1);
    chk("post-rst data", 64'(host.out_data), 64'(rec(TS_W'(0), 3, 7, 6)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xenos_fault_logger.md
Name: xenos_fault_logger

Overview:
Downstream consumer of the XENOS top-level fault outputs (fault_detected, fault_code, fault_channel, current_state). It turns each new fault condition into a timestamped event record. Records are buffered in a FIFO and drained by the supervisory host/CPU bridge over a valid/ready interface. Overflow is tracked with a sticky flag and a saturating drop counter, so that fault history is never silently lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
TS_W, 32, free-running timestamp width in bits
HOLDOFF, 1024, dedup window in cycles; used only when XENOS_LOG_DEDUP_EN is defined

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-high reset
fault_detected  input  1  fault flag from the XENOS top
fault_code  input  4  fault code from the XENOS top
fault_channel  input  4  faulting channel index, 0..11
current_state  input  3  XENOS FSM state
clear  input  1  synchronous flush of the FIFO and statistics
out_valid  output  1  head record available
out_ready  input  1  consumer accepts the head record
out_data  output  TS_W+11  record: [TS_W+10:11] timestamp, [10:8] state, [7:4] channel, [3:0] code
level  output  $clog2(DEPTH)+1  number of stored records
overflow  output  1  sticky: at least one event dropped
drop_cnt  output  16  dropped-event count; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1):
  - timestamp counter, FIFO pointers, level, overflow, drop_cnt all 0.
  - out_valid=0, out_data=0.
  - Registered copies of fault_detected, code and channel cleared to 0.
- Timestamp:
  - Increments by 1 every cycle and wraps modulo 2^TS_W.
  - Not affected by clear.
- Event detect, in cycle N:
  - event = fault_detected && (!fd_q || fault_code != code_q || fault_channel != chan_q), where the _q signals are the previous-cycle registered values.
  - Continuous assertion with an unchanged code and channel produces exactly one event.
  - A deassert followed by a reassert produces a new event.
- Push:
  - The record is built from the cycle-N inputs plus the cycle-N timestamp.
  - If the FIFO was empty, out_valid=1 with that record in cycle N+1 (1-cycle latency).
- Pop: occurs when out_valid && out_ready. The next entry, or out_valid=0, appears in the following cycle. out_data is stable while out_valid && !out_ready.
- Full FIFO:
  - Event with no simultaneous pop: the record is dropped, overflow is set, and drop_cnt increments (saturating).
  - Event with a simultaneous pop: both happen and level is unchanged.
- Empty FIFO: out_ready is ignored. Push and pop cannot coincide, because out_valid=0.
- out_data when out_valid=0: don't-care. Verification must not check it.
- clear=1:
  - Next cycle: level=0, out_valid=0, overflow=0, drop_cnt=0.
  - An event or pop in the same cycle is discarded.
  - The _q registers still update, so a fault that persists through clear is not re-logged.
- level: equals pushes minus pops since the last reset/clear. Range 0..DEPTH.
- Reset mid-operation: all stored records are lost and outputs return to their reset values immediately (asynchronous).
- Field widths: no arithmetic on record fields. Inputs are captured as-is, with no range check of fault_channel.

Optional Feature:
XENOS_LOG_DEDUP_EN
- Defined:
  - The block keeps the code, channel and timestamp of the last pushed record.
  - An event with the same code and channel is suppressed (not pushed, not counted as a drop) if fewer than HOLDOFF cycles have elapsed since that record's timestamp.
  - Elapsed time is computed modulo 2^TS_W, so timestamp wrap is handled.
  - Dedup memory is cleared by rst and clear.
- Undefined: every detected event is pushed or dropped as described above, and HOLDOFF is unused.

Test Plan:
- Single event: with rst released at cycle 0, assert fault_detected with code=4'h3, chan=5, state=2 at cycle 10 and hold it for 20 cycles; out_ready=0 -> exactly one record, timestamp=10, level=1, out_valid rises at cycle 11.
- Code change while detected: code goes 3 -> 7 at cycle 15 with chan=5 held -> two records (ts 10, 15), in order.
- Overflow: DEPTH=16, generate 20 distinct events with out_ready=0 -> level=16, overflow=1, drop_cnt=4; draining returns the first 16 events in order.
- Full plus simultaneous pop: FIFO full, out_ready=1 and a new event in the same cycle -> level stays 16, drop_cnt unchanged, the new record lands at the tail.
- Clear and backpressure: stall out_ready and confirm out_data stays stable; then pulse clear with 5 records stored -> level=0, overflow=0, out_valid=0 next cycle, and a persisting fault is not re-logged.
- Dedup (macro defined, HOLDOFF=1024): the same code/chan re-asserts after 100 cycles -> suppressed; re-asserts after 1100 cycles -> logged; drop_cnt stays 0.
